pipelined_adder: RTL

Parametrised, pipelined add/subtract unit that supersedes the single-cycle 2-bit combinational adder. The operand width is split into STAGES equal chunks, and each pipeline stage resolves one chunk's carry. Operands enter and results leave through valid/ready handshakes, so the block can sit between the ALU issue logic and writeback in the CPU datapath. It also adds a subtract mode, signed-overflow detection and a pipeline flush.

---
 rtl/pipelined_adder.sv | 105 ++++++++++
 1 files changed

// File: rtl/pipelined_adder.sv
// Pipelined add/subtract unit: each stage resolves the carry of one CW-bit chunk,
// with a global valid/ready stall, synchronous flush and signed-overflow output.
module pipelined_adder #(
   parameter int WIDTH  = 32,
   parameter int STAGES = 4
) (
   input  logic             clk_in,
   input  logic             rst_in,
   input  logic             flush_in,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);
   localparam int CW = WIDTH / STAGES;

   function automatic logic [CW:0] add_chunk(input logic [CW-1:0] x,
                                             input logic [CW-1:0] y,
                                             input logic          c);
      return {1'b0, x} + {1'b0, y} + {{CW{1'b0}}, c};
   endfunction

   // Carry into the MSB is recovered from the MSB operand and result bits.
   function automatic logic signed_ovf(input logic a_msb, input logic b_msb,
                                       input logic s_msb, input logic c_out);
      return (a_msb ^ b_msb ^ s_msb) ^ c_out;
   endfunction

   logic [STAGES-1:0] vld_p;
   logic              advance;

   assign advance   = !out_valid || out_ready;
   assign in_ready  = advance;
   assign out_valid = vld_p[STAGES-1];

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         vld_p <= '0;
      end else if (flush_in) begin
         vld_p <= '0;
      end else if (advance) begin
         vld_p[0] <= in_valid;
         for (int k = 1; k < STAGES; k++) vld_p[k] <= vld_p[k-1];
      end
   end

   for (genvar k = 0; k < STAGES; k++) begin : stg
      localparam int RW = WIDTH - k*CW;
      logic [RW-1:0]         a_in;
      logic [RW-1:0]         b_in;
      logic                  c_in;
      logic [CW:0]           r;
      logic [(k+1)*CW-1:0]   s_out;

      // Stage k boundary: operands still to add, carry and finished low chunks
      if (k == 0) begin : first
         assign a_in  = a;
         assign b_in  = sub ? ~b : b;
         assign c_in  = sub ? ~cin : cin;
         assign s_out = r[CW-1:0];
      end else begin : rest
         assign a_in  = stg[k-1].mid.a_p;
         assign b_in  = stg[k-1].mid.b_p;
         assign c_in  = stg[k-1].mid.c_p;
         assign s_out = {r[CW-1:0], stg[k-1].mid.s_p};
      end

      assign r = add_chunk(a_in[CW-1:0], b_in[CW-1:0], c_in);

      if (k < STAGES-1) begin : mid
         logic [RW-CW-1:0]    a_p;
         logic [RW-CW-1:0]    b_p;
         logic [(k+1)*CW-1:0] s_p;
         logic                c_p;

         always_ff @(posedge clk_in) begin
            if (advance) begin
               a_p <= a_in[RW-1:CW];
               b_p <= b_in[RW-1:CW];
               s_p <= s_out;
               c_p <= r[CW];
            end
         end
      end else begin : last
         always_ff @(posedge clk_in or posedge rst_in) begin
            if (rst_in) begin
               sum  <= '0;
               cout <= 1'b0;
               ovf  <= 1'b0;
            end else if (advance) begin
               sum  <= s_out;
               cout <= r[CW];
               ovf  <= signed_ovf(a_in[CW-1], b_in[CW-1], r[CW-1], r[CW]);
            end
         end
      end
   end
endmodule
